// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - brisc instruction fetch stage: PC, single-outstanding I-cache request, IF/ID register with 1-entry skid buffer
module fetch_stage #(
    parameter int unsigned           ADDR_LEN = 32,
    parameter int unsigned           ILEN     = 32,
    parameter logic [ADDR_LEN-1:0]   RESET_PC = 32'h0000_1000,
    parameter logic [ILEN-1:0]       NOP      = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [ADDR_LEN-1:0] redirect_pc_i,
    output logic                icache_req_valid,
    output logic [ADDR_LEN-1:0] icache_req_addr,
    input  logic                icache_req_ready,
    input  logic                icache_rsp_valid,
    input  logic [ILEN-1:0]     icache_rsp_instr,
    output logic                if_valid,
    output logic [ILEN-1:0]     if_instr,
    output logic [ADDR_LEN-1:0] if_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                state_q;
    logic [ADDR_LEN-1:0]   pc_q;
    logic [ADDR_LEN-1:0]   req_pc_q;
    logic                  buf_valid_q;
    logic [ILEN-1:0]       buf_instr_q;
    logic [ADDR_LEN-1:0]   buf_pc_q;
    logic                  if_valid_q;
    logic [ILEN-1:0]       if_instr_q;
    logic [ADDR_LEN-1:0]   if_pc_q;

    logic                  req_fire;
    logic                  rsp_take;
    logic                  slot_free;

    // Gated by rst_n so no request leaks out while the cache is held in reset.
    assign icache_req_valid = rst_n && (state_q == S_REQ) && !buf_valid_q && !redirect_i;
    assign icache_req_addr  = pc_q;
    assign req_fire         = icache_req_valid && icache_req_ready;
    assign rsp_take         = (state_q == S_WAIT) && icache_rsp_valid;
    assign slot_free        = !if_valid_q || !stall_i;

    assign if_valid = if_valid_q;
    assign if_instr = if_valid_q ? if_instr_q : NOP;
    assign if_pc    = if_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC & ~ADDR_LEN'(3);
            req_pc_q    <= '0;
            buf_valid_q <= 1'b0;
            buf_instr_q <= NOP;
            buf_pc_q    <= '0;
            if_valid_q  <= 1'b0;
            if_instr_q  <= NOP;
            if_pc_q     <= '0;
        end else if (redirect_i) begin
            pc_q        <= redirect_pc_i & ~ADDR_LEN'(3);
            if_valid_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            // An in-flight request still owes a response; S_DROP swallows it.
            case (state_q)
                S_WAIT:  state_q <= icache_rsp_valid ? S_REQ : S_DROP;
                S_DROP:  if (icache_rsp_valid) state_q <= S_REQ;
                default: state_q <= state_q;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + ADDR_LEN'(4);
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT:  if (icache_rsp_valid) state_q <= S_REQ;
                S_DROP:  if (icache_rsp_valid) state_q <= S_REQ;
                default: state_q <= S_REQ;
            endcase

            if (slot_free) begin
                if (buf_valid_q) begin
                    if_valid_q  <= 1'b1;
                    if_instr_q  <= buf_instr_q;
                    if_pc_q     <= buf_pc_q;
                    buf_valid_q <= 1'b0;
                end else if (rsp_take) begin
                    if_valid_q <= 1'b1;
                    if_instr_q <= icache_rsp_instr;
                    if_pc_q    <= req_pc_q;
                end else begin
                    if_valid_q <= 1'b0;
                end
            end else if (rsp_take) begin
                // Decode is stalled on a live instruction: park the response.
                buf_valid_q <= 1'b1;
                buf_instr_q <= icache_rsp_instr;
                buf_pc_q    <= req_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage: directed vector table, corner sequences, randomized run against a stream model
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_ready, icache_rsp_valid;
    logic [31:0] icache_rsp_instr;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;

    logic        d2_stall, d2_redir, d2_rdy, d2_rv;
    logic [31:0] d2_rpc, d2_ri;
    logic        d2_req_valid, d2_if_valid;
    logic [31:0] d2_req_addr, d2_if_instr, d2_if_pc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .icache_req_valid(icache_req_valid),
        .icache_req_addr(icache_req_addr), .icache_req_ready(icache_req_ready),
        .icache_rsp_valid(icache_rsp_valid), .icache_rsp_instr(icache_rsp_instr),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall_i(d2_stall), .redirect_i(d2_redir),
        .redirect_pc_i(d2_rpc), .icache_req_valid(d2_req_valid),
        .icache_req_addr(d2_req_addr), .icache_req_ready(d2_rdy),
        .icache_rsp_valid(d2_rv), .icache_rsp_instr(d2_ri),
        .if_valid(d2_if_valid), .if_instr(d2_if_instr), .if_pc(d2_if_pc)
    );

    typedef struct {
        logic        st, rd;
        logic [31:0] rpc;
        logic        rdy, rv;
        logic [31:0] ri;
        logic        e_rqv;
        logic [31:0] e_rqa;
        logic        e_ifv;
        logic [31:0] e_ifi, e_ifp;
    } vec_t;

    vec_t tv[19];

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic rdy, input logic rv, input logic [31:0] ri,
                                input logic e_rqv, input logic [31:0] e_rqa, input logic e_ifv,
                                input logic [31:0] e_ifi, input logic [31:0] e_ifp);
        vec_t v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.rv = rv; v.ri = ri;
        v.e_rqv = e_rqv; v.e_rqa = e_rqa; v.e_ifv = e_ifv; v.e_ifi = e_ifi; v.e_ifp = e_ifp;
        return v;
    endfunction

    // Cache content used by the random run: any fixed function of the address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic rdy, input logic rv, input logic [31:0] ri);
        stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
        icache_req_ready = rdy; icache_rsp_valid = rv; icache_rsp_instr = ri;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(O, O, 32'h0, O, O, 32'h0);
        d2_rdy = 1'b0; d2_rv = 1'b0; d2_ri = 32'h0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic        pending, hold_chk, redir_prev, stuck_prev;
        int          cnt, n_cons;
        logic [31:0] exp_pc, fetch_pc, hpc, hins, stuck_addr;

        d2_stall = 1'b0; d2_redir = 1'b0; d2_rpc = 32'h0;

        tv[0]  = mk(O, O, 32'h0,    I, O, 32'h0,        I, 32'h1000, O, NOP,          32'h0);
        tv[1]  = mk(O, O, 32'h0,    I, I, 32'h00500093, O, 32'h1004, O, NOP,          32'h0);
        tv[2]  = mk(I, O, 32'h0,    I, O, 32'h0,        I, 32'h1004, I, 32'h00500093, 32'h1000);
        tv[3]  = mk(I, O, 32'h0,    I, I, 32'h00A00113, O, 32'h1008, I, 32'h00500093, 32'h1000);
        tv[4]  = mk(I, O, 32'h0,    I, O, 32'h0,        O, 32'h1008, I, 32'h00500093, 32'h1000);
        tv[5]  = mk(O, O, 32'h0,    I, O, 32'h0,        O, 32'h1008, I, 32'h00500093, 32'h1000);
        tv[6]  = mk(O, O, 32'h0,    I, O, 32'h0,        I, 32'h1008, I, 32'h00A00113, 32'h1004);
        tv[7]  = mk(O, I, 32'h2002, I, O, 32'h0,        O, 32'h100C, O, NOP,          32'h1004);
        tv[8]  = mk(O, O, 32'h0,    I, O, 32'h0,        O, 32'h2000, O, NOP,          32'h1004);
        tv[9]  = mk(O, O, 32'h0,    I, I, 32'hDEADBEEF, O, 32'h2000, O, NOP,          32'h1004);
        tv[10] = mk(O, O, 32'h0,    I, O, 32'h0,        I, 32'h2000, O, NOP,          32'h1004);
        tv[11] = mk(O, I, 32'h2000, I, I, 32'h11111111, O, 32'h2004, O, NOP,          32'h1004);
        tv[12] = mk(O, O, 32'h0,    O, O, 32'h0,        I, 32'h2000, O, NOP,          32'h1004);
        tv[13] = mk(O, O, 32'h0,    O, O, 32'h0,        I, 32'h2000, O, NOP,          32'h1004);
        tv[14] = mk(O, O, 32'h0,    O, O, 32'h0,        I, 32'h2000, O, NOP,          32'h1004);
        tv[15] = mk(O, O, 32'h0,    I, O, 32'h0,        I, 32'h2000, O, NOP,          32'h1004);
        tv[16] = mk(O, O, 32'h0,    I, I, 32'h22222222, O, 32'h2004, O, NOP,          32'h1004);
        tv[17] = mk(O, O, 32'h0,    O, O, 32'h0,        I, 32'h2004, I, 32'h22222222, 32'h2000);
        tv[18] = mk(O, O, 32'h0,    O, O, 32'h0,        I, 32'h2004, O, NOP,          32'h2000);

        do_reset();
        #1;
        chk("reset req_valid", 32'(icache_req_valid), 32'h0);
        chk("reset if_valid",  32'(if_valid),         32'h0);
        chk("reset if_instr",  if_instr,              NOP);
        chk("reset if_pc",     if_pc,                 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            if (i != 0) @(negedge clk);
            drive(tv[i].st, tv[i].rd, tv[i].rpc, tv[i].rdy, tv[i].rv, tv[i].ri);
            #1;
            chk($sformatf("vec%0d req_valid", i), 32'(icache_req_valid), 32'(tv[i].e_rqv));
            chk($sformatf("vec%0d req_addr", i),  icache_req_addr,       tv[i].e_rqa);
            chk($sformatf("vec%0d if_valid", i),  32'(if_valid),         32'(tv[i].e_ifv));
            chk($sformatf("vec%0d if_instr", i),  if_instr,              tv[i].e_ifi);
            chk($sformatf("vec%0d if_pc", i),     if_pc,                 tv[i].e_ifp);
        end

        // Reset asserted between edges while waiting on the cache with a live IF/ID entry.
        @(negedge clk); drive(O, O, 32'h0, I, O, 32'h0);
        @(negedge clk); drive(O, O, 32'h0, I, I, 32'h33333333);
        @(negedge clk); drive(I, O, 32'h0, I, O, 32'h0);
        @(negedge clk); drive(I, O, 32'h0, O, O, 32'h0);
        #2;
        chk("pre-reset if_valid", 32'(if_valid), 32'h1);
        chk("pre-reset if_pc",    if_pc,         32'h2004);
        rst_n = 1'b0;
        #1;
        chk("async reset if_valid",  32'(if_valid),         32'h0);
        chk("async reset if_instr",  if_instr,              NOP);
        chk("async reset req_valid", 32'(icache_req_valid), 32'h0);
        chk("async reset if_pc",     if_pc,                 32'h0);

        // Stale response in S_REQ after reset is ignored; wrap instance checks PC modulo arithmetic.
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(O, O, 32'h0, O, I, 32'h44444444);
        d2_rdy = 1'b1; d2_rv = 1'b0;
        #1;
        chk("wrap first req_valid", 32'(d2_req_valid), 32'h1);
        chk("wrap first req_addr",  d2_req_addr,       32'hFFFF_FFFC);
        @(negedge clk);
        drive(O, O, 32'h0, O, O, 32'h0);
        d2_rv = 1'b1; d2_ri = 32'hCAFE_0001;
        #1;
        chk("stale rsp if_valid", 32'(if_valid),         32'h0);
        chk("stale rsp req_valid", 32'(icache_req_valid), 32'h1);
        chk("stale rsp req_addr", icache_req_addr,       32'h1000);
        @(negedge clk);
        d2_rv = 1'b0;
        #1;
        chk("wrap second req_valid", 32'(d2_req_valid), 32'h1);
        chk("wrap second req_addr",  d2_req_addr,       32'h0000_0000);
        chk("wrap if_valid",         32'(d2_if_valid),  32'h1);
        chk("wrap if_pc",            d2_if_pc,          32'hFFFF_FFFC);
        chk("wrap if_instr",         d2_if_instr,       32'hCAFE_0001);

        // Random run: the consumed instruction stream must be the sequential PC stream,
        // restarting at the target after each redirect, with cache data matching each PC.
        do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        pending = 1'b0; cnt = 0; n_cons = 0;
        exp_pc = 32'h1000; fetch_pc = 32'h1000;
        hold_chk = 1'b0; redir_prev = 1'b0; stuck_prev = 1'b0;
        hpc = 32'h0; hins = 32'h0; stuck_addr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) @(negedge clk);
            stall_i          = ($urandom_range(0, 9) < 3);
            redirect_i       = ($urandom_range(0, 19) == 0);
            redirect_pc_i    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                           : 32'($urandom);
            icache_req_ready = ($urandom_range(0, 3) != 0);
            icache_rsp_valid = pending && (cnt == 0);
            icache_rsp_instr = icache_rsp_valid ? mem(fetch_pc - 32'd4) : 32'($urandom);
            #1;
            if (!if_valid) chk("rnd nop when invalid", if_instr, NOP);
            if (hold_chk) begin
                chk("rnd stall hold valid", 32'(if_valid), 32'h1);
                chk("rnd stall hold pc",    if_pc,         hpc);
                chk("rnd stall hold instr", if_instr,      hins);
            end
            if (redir_prev) chk("rnd redirect kills if_valid", 32'(if_valid), 32'h0);
            if (stuck_prev) begin
                chk("rnd req held valid", 32'(icache_req_valid || redirect_i), 32'h1);
                if (icache_req_valid) chk("rnd req held addr", icache_req_addr, stuck_addr);
            end
            if (icache_req_valid) chk("rnd one outstanding", 32'(pending), 32'h0);
            if (icache_req_valid && icache_req_ready) chk("rnd req addr seq", icache_req_addr, fetch_pc);
            if (if_valid && !stall_i && !redirect_i) begin
                chk("rnd consume pc",    if_pc,    exp_pc);
                chk("rnd consume instr", if_instr, mem(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_cons++;
            end

            hold_chk   = if_valid && stall_i && !redirect_i;
            hpc        = if_pc;
            hins       = if_instr;
            redir_prev = redirect_i;
            stuck_prev = icache_req_valid && !icache_req_ready;
            stuck_addr = icache_req_addr;
            if (icache_rsp_valid) pending = 1'b0;
            else if (pending) cnt--;
            if (redirect_i) begin
                exp_pc   = redirect_pc_i & ~32'd3;
                fetch_pc = exp_pc;
            end else if (icache_req_valid && icache_req_ready) begin
                pending  = 1'b1;
                cnt      = $urandom_range(0, 2);
                fetch_pc = fetch_pc + 32'd4;
            end
        end
        chk("rnd progress (consumed >= 100)", 32'(n_cons >= 100), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
